// File: rtl/fb_swap_controller.sv
// Double-buffer sequencer: swaps the front buffer on a vsync fall after a finished frame,
// clears the new back buffer through both write ports, then releases the renderer.
module fb_swap_controller #(
    parameter int         FB_SIZE     = 307200,
    parameter int         ADDR_W      = 19,
    parameter logic [3:0] CLEAR_COLOR = 4'h0,
    parameter bit         CLEAR_EN    = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vsync,
    input  logic              render_done,
    input  logic [ADDR_W-1:0] rnd_addr1,
    input  logic [ADDR_W-1:0] rnd_addr2,
    input  logic [3:0]        rnd_data1,
    input  logic [3:0]        rnd_data2,
    input  logic              rnd_wr1_en,
    input  logic              rnd_wr2_en,
    output logic [ADDR_W-1:0] addr_wr1,
    output logic [ADDR_W-1:0] addr_wr2,
    output logic [3:0]        data_wr1,
    output logic [3:0]        data_wr2,
    output logic              wr1_en,
    output logic              wr2_en,
    output logic              read_pick,
    output logic              render_go,
    output logic              busy,
    output logic [7:0]        missed_cnt
);

    localparam logic [1:0] ST_RENDER     = 2'd0;
    localparam logic [1:0] ST_WAIT_VSYNC = 2'd1;
    localparam logic [1:0] ST_CLEAR      = 2'd2;

    localparam logic [ADDR_W:0] FB_SIZE_P = (ADDR_W + 1)'(FB_SIZE);
    localparam logic [ADDR_W:0] ONE_P     = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] TWO_P     = (ADDR_W + 1)'(2);

    logic [1:0]      state;
    logic [ADDR_W:0] ptr;
    logic [ADDR_W:0] ptr_p1;
    logic [ADDR_W:0] ptr_p2;
    logic            vsync_p0;
    logic            vsync_p1;
    logic            vsync_p2;
    logic            vfall;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // vsync_p0/p1 form the synchronizer, vsync_p2 is the previous synchronized sample
    assign vfall  = vsync_p2 & ~vsync_p1;
    assign ptr_p1 = ptr + ONE_P;
    assign ptr_p2 = ptr + TWO_P;
    assign busy   = (state != ST_RENDER);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_CLEAR;
            ptr        <= '0;
            vsync_p0   <= 1'b1;
            vsync_p1   <= 1'b1;
            vsync_p2   <= 1'b1;
            read_pick  <= 1'b0;
            render_go  <= 1'b0;
            missed_cnt <= 8'd0;
            addr_wr1   <= '0;
            addr_wr2   <= '0;
            data_wr1   <= 4'd0;
            data_wr2   <= 4'd0;
            wr1_en     <= 1'b0;
            wr2_en     <= 1'b0;
        end else begin
            vsync_p0  <= vsync;
            vsync_p1  <= vsync_p0;
            vsync_p2  <= vsync_p1;
            render_go <= 1'b0;
            case (state)
                ST_RENDER: begin
                    addr_wr1 <= rnd_addr1;
                    addr_wr2 <= rnd_addr2;
                    data_wr1 <= rnd_data1;
                    data_wr2 <= rnd_data2;
                    wr1_en   <= rnd_wr1_en;
                    wr2_en   <= rnd_wr2_en;
                    // A frame finishing on the same cycle as a vsync fall is not a miss;
                    // the swap simply waits for the following fall.
                    if (render_done)
                        state <= ST_WAIT_VSYNC;
                    else if (vfall)
                        missed_cnt <= sat_inc(missed_cnt);
                end
                ST_WAIT_VSYNC: begin
                    addr_wr1 <= rnd_addr1;
                    addr_wr2 <= rnd_addr2;
                    data_wr1 <= rnd_data1;
                    data_wr2 <= rnd_data2;
                    wr1_en   <= 1'b0;
                    wr2_en   <= 1'b0;
                    if (vfall) begin
                        read_pick <= ~read_pick;
                        if (CLEAR_EN) begin
                            state <= ST_CLEAR;
                            ptr   <= '0;
                        end else begin
                            render_go <= 1'b1;
                            state     <= ST_RENDER;
                        end
                    end
                end
                ST_CLEAR: begin
                    // ptr stops at or just past FB_SIZE; that extra cycle issues render_go
                    if (ptr < FB_SIZE_P) begin
                        addr_wr1 <= ptr[ADDR_W-1:0];
                        addr_wr2 <= ptr_p1[ADDR_W-1:0];
                        data_wr1 <= CLEAR_COLOR;
                        data_wr2 <= CLEAR_COLOR;
                        wr1_en   <= 1'b1;
                        wr2_en   <= (ptr_p1 < FB_SIZE_P);
                        ptr      <= ptr_p2;
                    end else begin
                        wr1_en    <= 1'b0;
                        wr2_en    <= 1'b0;
                        render_go <= 1'b1;
                        state     <= ST_RENDER;
                    end
                    if (vfall)
                        missed_cnt <= sat_inc(missed_cnt);
                end
                default: begin
                    state <= ST_CLEAR;
                    ptr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_swap_controller.sv
// Bench for fb_swap_controller: three configurations share one stimulus stream and are
// checked every cycle against a frame-level reference model, plus pinned literal values.
module tb_fb_swap_controller;

    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vsync = 1'b1;
    logic          render_done = 1'b0;
    logic [AW-1:0] rnd_addr1 = '0;
    logic [AW-1:0] rnd_addr2 = '0;
    logic [3:0]    rnd_data1 = 4'd0;
    logic [3:0]    rnd_data2 = 4'd0;
    logic          rnd_wr1_en = 1'b0;
    logic          rnd_wr2_en = 1'b0;

    logic [AW-1:0] o_a1 [3];
    logic [AW-1:0] o_a2 [3];
    logic [3:0]    o_d1 [3];
    logic [3:0]    o_d2 [3];
    logic          o_e1 [3];
    logic          o_e2 [3];
    logic          o_rp [3];
    logic          o_go [3];
    logic          o_busy [3];
    logic [7:0]    o_miss [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Config 0: 16 pixels, clearing. Config 1: 15 pixels, clearing. Config 2: 16 pixels, no clear.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        fb_swap_controller #(
            .FB_SIZE    ((g == 1) ? 15 : 16),
            .ADDR_W     (AW),
            .CLEAR_COLOR(4'h0),
            .CLEAR_EN   ((g == 2) ? 1'b0 : 1'b1)
        ) dut (
            .clock      (clk),
            .reset      (rst),
            .vsync      (vsync),
            .render_done(render_done),
            .rnd_addr1  (rnd_addr1),
            .rnd_addr2  (rnd_addr2),
            .rnd_data1  (rnd_data1),
            .rnd_data2  (rnd_data2),
            .rnd_wr1_en (rnd_wr1_en),
            .rnd_wr2_en (rnd_wr2_en),
            .addr_wr1   (o_a1[g]),
            .addr_wr2   (o_a2[g]),
            .data_wr1   (o_d1[g]),
            .data_wr2   (o_d2[g]),
            .wr1_en     (o_e1[g]),
            .wr2_en     (o_e2[g]),
            .read_pick  (o_rp[g]),
            .render_go  (o_go[g]),
            .busy       (o_busy[g]),
            .missed_cnt (o_miss[g])
        );
    end

    function automatic int fb_of(input int c);
        return (c == 1) ? 15 : 16;
    endfunction

    function automatic bit clear_of(input int c);
        return (c != 2);
    endfunction

    task automatic check(input string name, input int c, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s[cfg%0d] t=%0t: got %0d, expected %0d", name, c, $time, act, exp);
        end
    endtask

    // Reference model: a frame is either being rendered, waiting for the swap, or being
    // cleared beat by beat (beat k writes pixels 2k and 2k+1, then one release step).
    typedef enum int {PH_RENDER, PH_WAIT, PH_CLEAR} phase_t;
    phase_t m_ph   [3];
    int     m_beat [3];
    int     m_a1 [3], m_a2 [3], m_d1 [3], m_d2 [3];
    bit     m_e1 [3], m_e2 [3], m_rp [3], m_go [3];
    int     m_miss [3];
    // raw vsync as sampled 1, 2 and 3 edges ago; a fall is seen when (3 ago, 2 ago) = (1, 0)
    bit     m_v1 = 1'b1, m_v2 = 1'b1, m_v3 = 1'b1;
    wire    m_vf = m_v3 & ~m_v2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v1 <= 1'b1; m_v2 <= 1'b1; m_v3 <= 1'b1;
            for (int c = 0; c < 3; c++) begin
                m_ph[c] <= PH_CLEAR; m_beat[c] <= 0;
                m_a1[c] <= 0; m_a2[c] <= 0; m_d1[c] <= 0; m_d2[c] <= 0;
                m_e1[c] <= 1'b0; m_e2[c] <= 1'b0; m_rp[c] <= 1'b0; m_go[c] <= 1'b0;
                m_miss[c] <= 0;
            end
        end else begin
            m_v1 <= vsync; m_v2 <= m_v1; m_v3 <= m_v2;
            for (int c = 0; c < 3; c++) begin
                m_go[c] <= 1'b0;
                case (m_ph[c])
                    PH_RENDER: begin
                        m_a1[c] <= int'(rnd_addr1); m_a2[c] <= int'(rnd_addr2);
                        m_d1[c] <= int'(rnd_data1); m_d2[c] <= int'(rnd_data2);
                        m_e1[c] <= rnd_wr1_en;      m_e2[c] <= rnd_wr2_en;
                        if (render_done) m_ph[c] <= PH_WAIT;
                        else if (m_vf && m_miss[c] < 255) m_miss[c] <= m_miss[c] + 1;
                    end
                    PH_WAIT: begin
                        m_e1[c] <= 1'b0; m_e2[c] <= 1'b0;
                        if (m_vf) begin
                            m_rp[c] <= ~m_rp[c];
                            if (clear_of(c)) begin
                                m_ph[c] <= PH_CLEAR; m_beat[c] <= 0;
                            end else begin
                                m_ph[c] <= PH_RENDER; m_go[c] <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (m_beat[c] < (fb_of(c) + 1) / 2) begin
                            m_a1[c] <= 2 * m_beat[c]; m_a2[c] <= 2 * m_beat[c] + 1;
                            m_d1[c] <= 0; m_d2[c] <= 0;
                            m_e1[c] <= 1'b1; m_e2[c] <= (2 * m_beat[c] + 1 < fb_of(c));
                            m_beat[c] <= m_beat[c] + 1;
                        end else begin
                            m_e1[c] <= 1'b0; m_e2[c] <= 1'b0;
                            m_go[c] <= 1'b1; m_ph[c] <= PH_RENDER;
                        end
                        if (m_vf && m_miss[c] < 255) m_miss[c] <= m_miss[c] + 1;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            check("wr1_en", c, o_e1[c], m_e1[c]);
            check("wr2_en", c, o_e2[c], m_e2[c]);
            if (m_e1[c]) begin
                check("addr_wr1", c, o_a1[c], m_a1[c]);
                check("data_wr1", c, o_d1[c], m_d1[c]);
            end
            if (m_e2[c]) begin
                check("addr_wr2", c, o_a2[c], m_a2[c]);
                check("data_wr2", c, o_d2[c], m_d2[c]);
            end
            check("read_pick", c, o_rp[c], m_rp[c]);
            check("render_go", c, o_go[c], m_go[c]);
            check("busy", c, o_busy[c], (m_ph[c] != PH_RENDER));
            check("missed_cnt", c, o_miss[c], m_miss[c]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_fall(input int low_len, input int high_len);
        vsync = 1'b0;
        repeat (low_len) tick();
        vsync = 1'b1;
        repeat (high_len) tick();
    endtask

    int hold;

    initial begin
        // Reset then release: 8 clear beats, then render_go
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1) begin
                check("lit_beat0_addr1", 0, o_a1[0], 0);
                check("lit_beat0_addr2", 0, o_a2[0], 1);
                check("lit_beat0_en2", 0, o_e2[0], 1);
            end
            if (i == 8) begin
                check("lit_last_addr2", 0, o_a2[0], 15);
                check("lit_last_addr1_fb15", 1, o_a1[1], 14);
                check("lit_last_en2_fb15", 1, o_e2[1], 0);
            end
            if (i == 9) begin
                check("lit_go_after_clear", 0, o_go[0], 1);
                check("lit_go_after_clear", 1, o_go[1], 1);
                check("lit_busy_render", 0, o_busy[0], 0);
                check("lit_read_pick", 0, o_rp[0], 0);
            end
            if (i == 10) check("lit_go_one_cycle", 0, o_go[0], 0);
        end

        // Renderer passthrough
        rnd_addr1 = 19'd5; rnd_data1 = 4'd9; rnd_wr1_en = 1'b1;
        tick();
        check("lit_pass_addr1", 0, o_a1[0], 5);
        check("lit_pass_data1", 0, o_d1[0], 9);
        check("lit_pass_en1", 0, o_e1[0], 1);
        rnd_addr1 = '0; rnd_data1 = 4'd0; rnd_wr1_en = 1'b0;
        tick();

        // Two vsync falls without a finished frame
        vsync_fall(4, 4);
        vsync_fall(4, 4);
        check("lit_missed_two", 0, o_miss[0], 2);

        // Finished frame then vsync fall: swap three edges after the raw fall
        render_done = 1'b1;
        tick();
        render_done = 1'b0;
        check("lit_busy_wait", 0, o_busy[0], 1);
        vsync = 1'b0;
        tick(); tick();
        check("lit_no_swap_yet", 0, o_rp[0], 0);
        tick();
        check("lit_swap", 0, o_rp[0], 1);
        check("lit_swap_noclear", 2, o_rp[2], 1);
        check("lit_go_noclear", 2, o_go[2], 1);
        check("lit_en_at_swap", 0, o_e1[0], 0);
        tick();
        check("lit_clear_restart", 0, o_a1[0], 0);
        check("lit_clear_en", 0, o_e1[0], 1);
        check("lit_go_noclear_end", 2, o_go[2], 0);
        vsync = 1'b1;
        repeat (12) tick();

        // Reset in the middle of a clear
        render_done = 1'b1;
        tick();
        render_done = 1'b0;
        vsync = 1'b0;
        repeat (3) tick();
        vsync = 1'b1;
        repeat (3) tick();
        check("lit_mid_clear_addr", 0, o_a1[0], 4);
        rst = 1'b1;
        #1;
        check("lit_async_rst_addr", 0, o_a1[0], 0);
        check("lit_async_rst_en", 0, o_e1[0], 0);
        check("lit_async_rst_miss", 0, o_miss[0], 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("lit_restart_addr1", 0, o_a1[0], 0);
        check("lit_restart_addr2", 0, o_a2[0], 1);
        repeat (10) tick();

        // Missed-frame counter saturation
        for (int i = 0; i < 300; i++) vsync_fall(2, 2);
        tick();
        check("lit_miss_sat", 0, o_miss[0], 255);
        check("lit_miss_sat", 2, o_miss[2], 255);

        // Randomized traffic
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hold = 10;
        for (int i = 0; i < 4000; i++) begin
            render_done = ($urandom_range(0, 23) == 0);
            rnd_addr1   = 19'($urandom);
            rnd_addr2   = 19'($urandom);
            rnd_data1   = 4'($urandom);
            rnd_data2   = 4'($urandom);
            rnd_wr1_en  = 1'($urandom);
            rnd_wr2_en  = 1'($urandom);
            hold--;
            if (hold <= 0) begin
                vsync = ~vsync;
                hold  = $urandom_range(1, 40);
            end
            if (i == 2000) rst = 1'b1;
            if (i == 2001) rst = 1'b0;
            tick();
        end
        render_done = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
